// File: rtl/ahb_lite_fir_filter_ntap.sv
// ---------------------------------------------------------------------------
// ahb_lite_fir_filter_ntap
//   AHB-Lite slave FIR filter. Samples written over the bus are queued in a
//   small FIFO. A sequential MAC engine then produces one output per sample,
//   working through one tap per cycle. Coefficients are double-buffered. Bus
//   writes land in a shadow set, and a COEFSET commit copies that set into the
//   active set used by the engine.
//
//   Optional feature macro: FIR_IRQ_EN (adds the irq output).
//
// Ports
//   clk     in   1       system clock, all state on rising edge
//   n_rst   in   1       synchronous active-low reset
//   hsel    in   1       slave select
//   haddr   in   ADDR_W  byte address
//   hsize   in   1       0=byte, 1=halfword
//   htrans  in   2       IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   hwrite  in   1       1=write
//   hwdata  in   16      write data (data phase)
//   hrdata  out  16      read data (data phase)
//   hresp   out  1       error response (data phase)
//   irq     out  1       result-ready interrupt (FIR_IRQ_EN only)
//
// Register map (halfword index = haddr[ADDR_W-1:1])
//   0 STATUS  RO  bit0 busy, bit8 err
//   1 RESULT  RO  last output
//   2 SAMPLE  WO  push to FIFO; reads return FIFO head (0 when empty)
//   3 COEFSET RW  bit0=1 requests commit; reads 1 while pending
//   4+k       RW  shadow coefficient k
// ---------------------------------------------------------------------------
module ahb_lite_fir_filter_ntap #(
    parameter int TAPS       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hsize,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [15:0]       hwdata,
    output logic [15:0]       hrdata,
    output logic              hresp
`ifdef FIR_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CNT_W = $clog2(TAPS);
    localparam int ACC_W = 32 + CNT_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMIT,
        S_LOAD,
        S_MAC,
        S_DONE
    } state_t;

    // Bus protocol: an address phase is accepted whenever hsel && htrans[1].
    // It is captured in the dp_* registers and completes unconditionally in
    // the following cycle, because the slave never inserts wait states. The
    // data phase drives hrdata/hresp combinationally from those registers.
    state_t            state_q, state_d;
    logic              dp_valid_q, dp_valid_d;
    logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
    logic              dp_write_q, dp_write_d;
    logic              dp_size_q, dp_size_d;

    logic [15:0]       fifo_q [FIFO_DEPTH];
    logic [15:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic [15:0]       x_q [TAPS];
    logic [15:0]       x_d [TAPS];
    logic [15:0]       coef_shadow_q [TAPS];
    logic [15:0]       coef_shadow_d [TAPS];
    logic [15:0]       coef_active_q [TAPS];
    logic [15:0]       coef_active_d [TAPS];

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       result_q, result_d;
    logic              err_q, err_d;
    logic              commit_pend_q, commit_pend_d;
    logic              irq_q, irq_d;

    // Data-phase decode
    logic [31:0]       idx_w;
    logic              misalign;
    logic              unmapped;
    logic              fifo_full;
    logic              fifo_empty;
    logic              bus_err;
    logic              wr_en;
    logic              rd_en;
    logic              busy;
    logic [15:0]       fifo_head;
    logic [15:0]       rdata;
    logic [31:0]       prod;
    logic              push;
    logic              pop;

    logic              unused_htrans;
    assign unused_htrans = htrans[0];

    // Merge write data into an existing halfword according to the byte lane.
    function automatic logic [15:0] merge_lanes(input logic [15:0] old_v,
                                                input logic [15:0] wd,
                                                input logic        sz,
                                                input logic        hi);
        if (sz)
            return wd;
        else if (hi)
            return {wd[15:8], old_v[7:0]};
        else
            return {old_v[15:8], wd[7:0]};
    endfunction

    always_comb begin
        idx_w      = 32'(dp_addr_q[ADDR_W-1:1]);
        misalign   = dp_size_q && dp_addr_q[0];
        unmapped   = idx_w >= 32'(4 + TAPS);
        fifo_full  = count_q == (PTR_W+1)'(FIFO_DEPTH);
        fifo_empty = count_q == '0;
        fifo_head  = fifo_q[rd_ptr_q];
        // A full FIFO rejects a push even if the engine pops in the same cycle.
        bus_err    = dp_valid_q && (misalign || unmapped ||
                                    (dp_write_q && idx_w < 32'd2) ||
                                    (dp_write_q && idx_w == 32'd2 && fifo_full));
        wr_en      = dp_valid_q && dp_write_q && !bus_err;
        rd_en      = dp_valid_q && !dp_write_q && !bus_err;
        busy       = (state_q != S_IDLE) || !fifo_empty || commit_pend_q;

        rdata = 16'h0000;
        if (idx_w == 32'd0)
            rdata = {7'b0, err_q, 7'b0, busy};
        else if (idx_w == 32'd1)
            rdata = result_q;
        else if (idx_w == 32'd2)
            rdata = fifo_empty ? 16'h0000 : fifo_head;
        else if (idx_w == 32'd3)
            rdata = {15'b0, commit_pend_q};
        else begin
            for (int k = 0; k < TAPS; k++) begin
                if (idx_w == 32'(4 + k))
                    rdata = coef_shadow_q[k];
            end
        end
    end

    assign hrdata = rd_en ? rdata : 16'h0000;
    assign hresp  = bus_err;

    always_comb begin
        state_d       = state_q;
        dp_valid_d    = hsel && htrans[1];
        dp_addr_d     = haddr;
        dp_write_d    = hwrite;
        dp_size_d     = hsize;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        x_d           = x_q;
        coef_shadow_d = coef_shadow_q;
        coef_active_d = coef_active_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        err_d         = err_q;
        commit_pend_d = commit_pend_q;
        irq_d         = irq_q;
        prod          = {16'h0000, x_q[cnt_q]} * {16'h0000, coef_active_q[cnt_q]};

        // Commit outranks LOAD so samples queued after a COEFSET write see the new set.
        pop  = (state_q == S_IDLE) && !commit_pend_q && !fifo_empty;
        push = wr_en && (idx_w == 32'd2);

        // Engine FSM
        case (state_q)
            S_IDLE: begin
                if (commit_pend_q) begin
                    state_d = S_COMMIT;
                end else if (!fifo_empty) begin
                    state_d = S_LOAD;
                    x_d[0]  = fifo_head;
                    for (int k = 1; k < TAPS; k++)
                        x_d[k] = x_q[k-1];
                end
            end
            S_COMMIT: begin
                coef_active_d = coef_shadow_q;
                commit_pend_d = 1'b0;
                state_d       = S_IDLE;
            end
            S_LOAD: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + {{CNT_W{1'b0}}, prod};
                if (cnt_q == CNT_W'(TAPS - 1))
                    state_d = S_DONE;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                // Output is acc>>16; any bit above bit 31 means it exceeds 16 bits.
                if (|acc_q[ACC_W-1:32]) begin
                    result_d = 16'hFFFF;
                    err_d    = 1'b1;
                end else begin
                    result_d = acc_q[31:16];
                    err_d    = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // FIFO bookkeeping
        if (push) begin
            fifo_d[wr_ptr_q] = merge_lanes(16'h0000, hwdata, dp_size_q, dp_addr_q[0]);
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)
            count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push)
            count_d = count_q - (PTR_W+1)'(1);

        // Bus register writes. A COEFSET request landing during COMMIT re-arms
        // the pending flag, so it is placed after the FSM.
        if (wr_en && idx_w == 32'd3 && (dp_size_q || !dp_addr_q[0]) && hwdata[0])
            commit_pend_d = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
            if (wr_en && idx_w == 32'(4 + k))
                coef_shadow_d[k] = merge_lanes(coef_shadow_q[k], hwdata, dp_size_q, dp_addr_q[0]);
        end

        // A DONE coinciding with the clearing RESULT read keeps irq set.
        if (rd_en && idx_w == 32'd1)
            irq_d = 1'b0;
        if (state_q == S_DONE)
            irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            dp_valid_q    <= 1'b0;
            dp_addr_q     <= '0;
            dp_write_q    <= 1'b0;
            dp_size_q     <= 1'b0;
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            x_q           <= '{default: '0};
            coef_shadow_q <= '{default: '0};
            coef_active_q <= '{default: '0};
            acc_q         <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            err_q         <= 1'b0;
            commit_pend_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            dp_valid_q    <= dp_valid_d;
            dp_addr_q     <= dp_addr_d;
            dp_write_q    <= dp_write_d;
            dp_size_q     <= dp_size_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            x_q           <= x_d;
            coef_shadow_q <= coef_shadow_d;
            coef_active_q <= coef_active_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            err_q         <= err_d;
            commit_pend_q <= commit_pend_d;
            irq_q         <= irq_d;
        end
    end

`ifdef FIR_IRQ_EN
    assign irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif

endmodule
